// File: rtl/fuel_gauge_ctrl.sv
// fuel_gauge_ctrl: HUD fuel level FSM, FUEL label coordinates and fuel bar.
// Define FUEL_BLINK_EN to blink the bar while fuel is low.
module fuel_gauge_ctrl #(
  parameter int         LABEL_X      = 16,
  parameter int         LABEL_Y      = 8,
  parameter int         LABEL_W      = 32,
  parameter int         LABEL_H      = 16,
  parameter int         BAR_X        = 56,
  parameter int         BAR_Y        = 12,
  parameter int         BAR_H        = 8,
  parameter int         FUEL_MAX     = 100,
  parameter int         DRAIN_FRAMES = 30,
  parameter int         REFILL       = 25,
  parameter int         LOW_THRESH   = 20,
  parameter logic [7:0] BAR_COLOR    = 8'b00011100,
  parameter logic [7:0] LOW_COLOR    = 8'b11100000,
  parameter int         BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        gameStart,
  input  logic        fuelPickup,
  output logic        labelInside,
  output logic [10:0] labelOffsetX,
  output logic [10:0] labelOffsetY,
  output logic        fuelBarDR,
  output logic [7:0]  fuelBarRGB,
  output logic        fuelLow,
  output logic        fuelEmpty,
  output logic [6:0]  fuelLevel
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_LOW, S_EMPTY
  } state_t;

  localparam int            CW       = $clog2(DRAIN_FRAMES);
  localparam logic [6:0]    LVL_MAX  = 7'(FUEL_MAX);
  localparam logic [6:0]    LVL_LOW  = 7'(LOW_THRESH);
  localparam logic [7:0]    REF8     = 8'(REFILL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_FRAMES - 1);

  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be positive");
  end

  state_t        state, state_nx;
  logic [6:0]    level, level_nx, disp;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    sum;
  logic          dec;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      level <= LVL_MAX;
      disp  <= LVL_MAX;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      cnt   <= cnt_nx;
      if (startOfFrame) disp <= level;
    end
  end

  // State reacts to the registered level, one cycle after it changes
  always_comb begin
    state_nx = state;
    level_nx = level;
    cnt_nx   = cnt;
    sum      = {1'b0, level};
    dec      = 1'b0;
    if (gameStart) begin
      state_nx = S_RUN;
      level_nx = LVL_MAX;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_RUN, S_LOW: begin
          if (level == 7'd0)         state_nx = S_EMPTY;
          else if (level <= LVL_LOW) state_nx = S_LOW;
          else                       state_nx = S_RUN;
          if (startOfFrame) begin
            if (cnt == CNT_LAST) begin
              cnt_nx = '0;
              dec    = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          if (fuelPickup) sum = sum + REF8;
          if (dec && sum != 8'd0) sum = sum - 8'd1;
          level_nx = (sum > {1'b0, LVL_MAX}) ? LVL_MAX : sum[6:0];
        end
        default: ;
      endcase
    end
  end

  assign fuelLow   = (state == S_LOW);
  assign fuelEmpty = (state == S_EMPTY);
  assign fuelLevel = level;

  logic lab_in;
  assign lab_in = pixelX >= 11'(LABEL_X)
               && pixelX <  11'(LABEL_X + LABEL_W)
               && pixelY >= 11'(LABEL_Y)
               && pixelY <  11'(LABEL_Y + LABEL_H);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      labelInside  <= 1'b0;
      labelOffsetX <= '0;
      labelOffsetY <= '0;
    end else begin
      labelInside  <= lab_in;
      labelOffsetX <= lab_in ? pixelX - 11'(LABEL_X) : '0;
      labelOffsetY <= lab_in ? pixelY - 11'(LABEL_Y) : '0;
    end
  end

  logic bar_hit, show, hit_q, warn_q;
  logic [7:0] bar_col;
  assign bar_hit = pixelY >= 11'(BAR_Y)
                && pixelY <  11'(BAR_Y + BAR_H)
                && pixelX >= 11'(BAR_X)
                && pixelX <  11'(BAR_X) + {4'd0, disp};

`ifdef FUEL_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] bcnt;
  logic          blink;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (state != S_LOW) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (startOfFrame) begin
      if (bcnt == BLK_LAST) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign show = bar_hit && !blink;
`else
  assign show = bar_hit;
`endif

  assign bar_col = !hit_q ? 8'h00 : (warn_q ? LOW_COLOR : BAR_COLOR);

  // Two stages so the bar lines up with the label bitmap output
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q      <= 1'b0;
      warn_q     <= 1'b0;
      fuelBarRGB <= 8'h00;
      fuelBarDR  <= 1'b0;
    end else begin
      hit_q      <= show;
      warn_q     <= (state == S_LOW) || (state == S_EMPTY);
      fuelBarRGB <= bar_col;
      fuelBarDR  <= (bar_col != 8'h00);
    end
  end

endmodule

// File: doc/fuel_gauge_ctrl.md
Name: fuel_gauge_ctrl

Overview:
- Owns the fuel resource for the HUD.
- Holds a fuel-level counter that drains once per N frames while the game runs, refills on pickups, and exposes low/empty status to game logic.
- On the rendering side it is the coordinate producer for the "FUEL" header bitmap: it emits the inside-rectangle flag and the 32x16 label offsets.
- It also draws a fuel bar, with DR/RGB aligned to the bitmap's output.

Parameters:
- LABEL_X, 16, label top-left X.
- LABEL_Y, 8, label top-left Y.
- LABEL_W, 32, label width (bitmap width).
- LABEL_H, 16, label height (bitmap height).
- BAR_X, 56, bar left X.
- BAR_Y, 12, bar top Y.
- BAR_H, 8, bar height in pixels.
- FUEL_MAX, 100, full level; also the bar length in pixels when full.
- DRAIN_FRAMES, 30, frames per 1-unit drain.
- REFILL, 25, units added per pickup.
- LOW_THRESH, 20, level at or below which fuel is low.
- BAR_COLOR, 8'b00011100, normal bar RGB.
- LOW_COLOR, 8'b11100000, bar RGB when low.
- BLINK_FRAMES, 8, blink half-period in frames (optional feature only).

Ports:
- clk  in  1  system clock
- resetN  in  1  reset; asynchronous, active-low
- pixelX  in  11  current pixel X
- pixelY  in  11  current pixel Y
- startOfFrame  in  1  one-cycle pulse per frame
- gameStart  in  1  one-cycle pulse: refuel and start running
- fuelPickup  in  1  one-cycle pulse: add REFILL
- labelInside  out  1  pixel is inside the label rectangle (registered)
- labelOffsetX  out  11  pixelX-LABEL_X when inside, else 0 (registered)
- labelOffsetY  out  11  pixelY-LABEL_Y when inside, else 0 (registered)
- fuelBarDR  out  1  bar draw request
- fuelBarRGB  out  8  bar colour; 8'h00 when not drawing
- fuelLow  out  1  state is LOW
- fuelEmpty  out  1  state is EMPTY
- fuelLevel  out  7  current level, 0..FUEL_MAX

Behaviour:
- Reset (async, resetN=0):
  - State IDLE; level=FUEL_MAX; displayed level=FUEL_MAX; frame counter 0.
  - All registered outputs 0; fuelLevel=FUEL_MAX.
- Label path, 1-cycle latency:
  - Inside when LABEL_X<=pixelX<LABEL_X+LABEL_W and LABEL_Y<=pixelY<LABEL_Y+LABEL_H.
  - Offsets are zero when not inside.
- Bar path, 2-cycle latency (two register stages), so it aligns with label pixels after the bitmap's own 1-cycle stage.
  - Drawn when BAR_X<=pixelX<BAR_X+dispLevel and BAR_Y<=pixelY<BAR_Y+BAR_H.
  - dispLevel=0 draws nothing.
  - fuelBarRGB is LOW_COLOR in LOW/EMPTY, BAR_COLOR otherwise, 8'h00 when not drawn.
  - fuelBarDR = (fuelBarRGB != 8'h00).
- dispLevel latches level on startOfFrame only, so the bar never tears mid-frame.
- States:
  - IDLE: no drain, pickups ignored.
  - RUN, LOW: drain active, pickups applied.
  - EMPTY: no drain, pickups ignored.
- gameStart, from any state: next cycle level=FUEL_MAX, frame counter=0, state=RUN. gameStart has priority over same-cycle pickup and drain.
- Drain tick, in RUN/LOW on startOfFrame:
  - Frame counter increments.
  - At DRAIN_FRAMES-1 the counter wraps to 0 and level decrements, saturating at 0.
- Pickup in RUN/LOW: level=min(level+REFILL, FUEL_MAX), computed 8 bits wide with no overflow.
- Pickup and drain tick in the same cycle: level=min(level+REFILL-1, FUEL_MAX).
- Transitions are evaluated on the post-update level, with the state change visible 1 cycle after the level update:
  - RUN to LOW when level<=LOW_THRESH.
  - LOW to RUN when level>LOW_THRESH.
  - RUN or LOW to EMPTY when level==0.
- EMPTY is terminal until gameStart.
- fuelLow is 1 only in LOW. fuelEmpty is 1 only in EMPTY.

Optional Feature:
- Macro FUEL_BLINK_EN.
- Defined:
  - A blink register toggles every BLINK_FRAMES startOfFrame pulses while in LOW.
  - While the blink register is 1, the bar is suppressed (DR=0, RGB=0).
  - The blink register is forced to 0 outside LOW and on reset.
- Undefined: no blink logic; the LOW bar is drawn solid in LOW_COLOR.

Test Plan:
- Label geometry: reset, then pixelX=20,pixelY=10 -> next cycle labelInside=1, offsets 4/2. Then pixelX=48 -> labelInside=0, offsets 0.
- Drain: gameStart, then 30 startOfFrame pulses -> level 99. 2400 pulses in total -> level 20, fuelLow=1, bar RGB=8'b11100000.
- Pickup saturation:
  - At level 90, fuelPickup -> level 100.
  - At level 20 (LOW), fuelPickup -> level 45, fuelLow=0 one cycle later.
- Simultaneous: pickup coincident with the drain tick at level 50 -> level 74.
- Empty/restart:
  - Drain to 0 -> fuelEmpty=1; pickups then ignored, level stays 0, bar not drawn.
  - gameStart -> level 100, state RUN.
  - resetN low mid-frame -> all outputs 0 asynchronously, fuelLevel=100.
- Bar alignment/tearing:
  - Level 40, pixelY=14, sweep pixelX -> fuelBarDR=1 exactly for X 56..95, 2 cycles after the input pixel.
  - Level change mid-frame does not alter the bar until the next startOfFrame.
